dm_data_cache: RTL

//  Read-only direct-mapped data cache that sits between the processor load port and main memory.

---
 rtl/dm_cache_pkg.sv | 41 ++++
 rtl/dm_cache_tag_store.sv | 51 +++++
 rtl/dm_data_cache.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dm_cache_pkg
// Brief   : Shared widths, FSM state type, address-field helpers and line
//           type for the read-only direct-mapped data cache.
// Revision: 1.0 - initial release
// ============================================================================
package dm_cache_pkg;

  localparam int ADDR_W         = 15;
  localparam int WORD_W         = 32;
  localparam int INDEX_W        = 10;
  localparam int OFFSET_W       = 2;
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_LINES      = 1 << INDEX_W;
  localparam int WORDS_PER_LINE = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    MISS_WAIT = 2'd2,
    RESPOND   = 2'd3
  } state_e;

  // Element [0] is the word at offset 0 of the block.
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage : dm_cache_pkg
`default_nettype wire

// File: rtl/dm_cache_tag_store.sv
`default_nettype none
// ============================================================================
// Module  : dm_cache_tag_store
// Brief   : Per-line valid bits (cleared by reset), tag array (not reset)
//           and the single lookup comparator producing the hit flag.
// Revision: 1.0 - initial release
// ============================================================================
module dm_cache_tag_store
  import dm_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_mem_q [NUM_LINES];

  // Next valid vector: a refill marks its line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Valid bits are the only cache state that reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag array write on refill; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_q[wr_idx] <= wr_tag;
    end
  end

  assign hit = valid_q[lookup_idx] && (tag_mem_q[lookup_idx] == lookup_tag);

endmodule : dm_cache_tag_store
`default_nettype wire

// File: rtl/dm_data_cache.sv
`default_nettype none
// ============================================================================
// Module  : dm_data_cache
// Brief   : Read-only direct-mapped data cache, 1024 lines x 4 words.
//           Hit answers one cycle after accept; a miss waits MEM_LATENCY
//           cycles, refills the whole block from memory, then answers.
//           Optional feature macro: DM_CACHE_STATS_EN (hit/miss counters).
// Revision: 1.0 - initial release
// ============================================================================
module dm_data_cache
  import dm_cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_w3,
  input  logic [WORD_W-1:0] mem_w2,
  input  logic [WORD_W-1:0] mem_w1,
  input  logic [WORD_W-1:0] mem_w0
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  // Wide enough to hold MEM_LATENCY-1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;

  logic                hit;
  logic                refill;
  logic                refill_we;
  logic                accept;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  line_t               hit_line;
  line_t               refill_line;
  line_t               data_mem_q [NUM_LINES];

  assign req_tag     = get_tag(req_q);
  assign req_idx     = get_index(req_q);
  assign req_off     = get_offset(req_q);
  assign hit_line    = data_mem_q[req_idx];
  assign refill_line = {mem_w3, mem_w2, mem_w1, mem_w0};

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign mem_addr  = mem_addr_q;
  // A reset arriving on the refill edge must leave the arrays untouched.
  assign refill_we = refill && !rst;

  dm_cache_tag_store u_tag_store (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (req_idx),
    .lookup_tag (req_tag),
    .hit        (hit),
    .wr_en      (refill_we),
    .wr_idx     (req_idx),
    .wr_tag     (req_tag)
  );

  // FSM next state, response outputs and datapath register updates.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_valid  = 1'b0;
    rsp_hit    = 1'b0;
    rsp_data   = rsp_data_q;
    refill     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = req_addr;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          rsp_valid  = 1'b1;
          rsp_hit    = 1'b1;
          rsp_data   = hit_line[req_off];
          rsp_data_d = hit_line[req_off];
          state_d    = IDLE;
        end else begin
          cnt_d      = CNT_W'(MEM_LATENCY - 1);
          mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
          state_d    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (cnt_q == '0) begin
          refill     = 1'b1;
          rsp_data_d = refill_line[req_off];
          state_d    = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        // rsp_data_q already holds the refilled word.
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Data array: whole-block write on refill; conflicts simply overwrite.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_mem_q[req_idx] <= refill_line;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // One saturating increment per lookup outcome.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == COMPARE) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  // Statistics counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule : dm_data_cache
`default_nettype wire
